periph_req_arb: RTL
===================

Name: periph_req_arb

Overview:
- Parametrised peripheral request front-end for the DMA controller.
- Captures level requests from up to NUM_PERIPH peripherals, in TX and RX directions, into pending latches.
- Round-robin arbitrates the pending latches into a single grant handshake toward the DMA channel engine.
- After the engine reports transfer completion, drives a CLR_CYCLES-wide clear pulse back to the granted peripheral and then holds off re-capture of that request.

Parameters:
- NUM_PERIPH, 31, number of peripherals. Indices are 1..NUM_PERIPH; bit 0 of every vector is reserved.
- CLR_CYCLES, 1, width of the clear pulse in clocks (>=1).
- HOLDOFF, 2, clocks after the clear pulse ends during which that slot's req is ignored (>=0).
- IDX_W, $clog2(NUM_PERIPH+1), width of the peripheral index.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- periph_tx_req  in  NUM_PERIPH+1  level TX requests; bit 0 ignored.
- periph_rx_req  in  NUM_PERIPH+1  level RX requests; bit 0 ignored.
- periph_tx_clr  out  NUM_PERIPH+1  TX clear pulses; bit 0 always 0.
- periph_rx_clr  out  NUM_PERIPH+1  RX clear pulses; bit 0 always 0.
- tx_en  in  NUM_PERIPH+1  per-peripheral TX enable.
- rx_en  in  NUM_PERIPH+1  per-peripheral RX enable.
- gnt_valid  out  1  grant offered.
- gnt_ready  in  1  engine accepts the grant.
- gnt_periph  out  IDX_W  granted peripheral index.
- gnt_dir  out  1  0 = TX, 1 = RX.
- xfer_done  in  1  single-cycle completion pulse for the accepted grant.
- tx_pend  out  NUM_PERIPH+1  TX pending status.
- rx_pend  out  NUM_PERIPH+1  RX pending status.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; round-robin pointer = slot before TX1; all holdoff counters = 0.
- Slot order: TX1, RX1, TX2, RX2, ... TXn, RXn, wrapping back to TX1.
- Capture: pend[s] is set at edge N+1 when, at edge N, all of the following hold:
  - req[s]=1 and en[s]=1;
  - pend[s]=0;
  - slot s is not granted or clearing;
  - holdoff[s]=0.
- Enable drop: en[s]=0 clears pend[s] next edge, but only if s is not the granted slot. A granted slot is unaffected by en.
- FSM states IDLE, GRANT, BUSY, CLR.
- IDLE:
  - If any pend, select the first pending slot strictly after the pointer.
  - Next edge: gnt_valid=1, gnt_periph/gnt_dir set, pointer = selected slot, state = GRANT.
  - Result: grant appears 2 clocks after req is sampled.
- GRANT:
  - gnt_valid, gnt_periph and gnt_dir stay stable until gnt_ready=1.
  - On the edge with gnt_valid & gnt_ready: gnt_valid drops next cycle, state = BUSY.
- BUSY:
  - xfer_done=1 -> state = CLR; the matching clr bit goes high next cycle.
  - xfer_done in any other state is ignored.
- CLR:
  - clr bit held for exactly CLR_CYCLES clocks.
  - On exit: clr=0, pend[s]=0, holdoff[s]=HOLDOFF, state = IDLE.
  - New arbitration may issue in the same cycle clr drops.
- Holdoff counters decrement once per clock down to 0, independently per slot.
- Simultaneous events:
  - If req rises on the slot just being cleared, it is ignored until its holdoff expires.
  - Other slots capture normally during any state.
- Only one grant is outstanding at a time; busy=1 in GRANT, BUSY and CLR.
- Reset mid-operation: next edge returns to the reset values above. Any clr pulse terminates immediately; pend is lost.

Optional Feature:
- Macro: PERIPH_REQ_SYNC_EN.
- Defined: periph_tx_req and periph_rx_req pass through a 2-flop synchronizer before capture. req-to-grant latency becomes 4 clocks. Synchronizer flops reset to 0.
- Undefined: requests are sampled directly; latency is 2 clocks.

Test Plan:
- Reset, all en=1, raise periph_tx_req[3] at cycle 5 -> tx_pend[3]=1 at cycle 6; gnt_valid=1, gnt_periph=3, gnt_dir=0 at cycle 7.
- Hold gnt_ready=0 for 4 cycles -> grant fields stable. Assert gnt_ready -> gnt_valid=0 next cycle, busy=1.
- CLR_CYCLES=3: pulse xfer_done -> periph_tx_clr[3] high for exactly 3 clocks. Keep req[3] high for 1 clock after clr ends -> no re-capture (HOLDOFF=2).
- Pending on TX2, RX2 and TX5 simultaneously, pointer reset -> grants in order TX2, RX2, TX5. Then re-raise TX2 -> granted after TX5 wraps the pointer.
- rx_en[7]=0 with periph_rx_req[7]=1 -> rx_pend[7] stays 0. Drop tx_en[4] while tx_pend[4] is pending but not granted -> tx_pend[4] cleared next edge.
- Assert reset during CLR with periph_rx_clr[9]=1 -> all outputs 0 next edge. After reset, an xfer_done pulse -> no effect.

Source files
------------

// File: rtl/periph_req_arb.sv
// periph_req_arb: peripheral request front-end for the DMA controller.
// Level TX/RX requests from peripherals 1..NUM_PERIPH are captured into
// pending latches, arbitrated round-robin over the slot ring
// TX1, RX1, TX2, RX2, ... into one grant handshake, and acknowledged with
// a CLR_CYCLES-wide clear pulse followed by a HOLDOFF re-capture blackout.
// Optional build macro PERIPH_REQ_SYNC_EN: requests pass through a
// 2-flop synchronizer before capture (req-to-grant latency 4 instead of 2).

module periph_req_arb #(
   parameter int NUM_PERIPH = 31,
   parameter int CLR_CYCLES = 1,
   parameter int HOLDOFF    = 2,
   parameter int IDX_W      = $clog2(NUM_PERIPH + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_PERIPH:0] periph_tx_req,
   input  logic [NUM_PERIPH:0] periph_rx_req,
   output logic [NUM_PERIPH:0] periph_tx_clr,
   output logic [NUM_PERIPH:0] periph_rx_clr,
   input  logic [NUM_PERIPH:0] tx_en,
   input  logic [NUM_PERIPH:0] rx_en,
   output logic                gnt_valid,
   input  logic                gnt_ready,
   output logic [IDX_W-1:0]    gnt_periph,
   output logic                gnt_dir,
   input  logic                xfer_done,
   output logic [NUM_PERIPH:0] tx_pend,
   output logic [NUM_PERIPH:0] rx_pend,
   output logic                busy
);

   // Slot k serves peripheral k/2+1; even slots are TX, odd slots are RX.
   localparam int NS    = 2 * NUM_PERIPH;
   localparam int SL_W  = $clog2(NS);
   localparam int CNT_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam int HO_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

   localparam logic [SL_W:0]   NS_W    = (SL_W + 1)'(NS);
   localparam logic [SL_W-1:0] PTR_RST = SL_W'(NS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      BUSY  = 2'd2,
      CLR   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [SL_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]  gp_q, gp_d;
   logic              gd_q, gd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              clr_done;

   logic [NUM_PERIPH:0] tx_req_eff, rx_req_eff;
   logic [NS-1:0]       req_slot, en_slot, pend_q;
   logic                owned;
   logic                found;
   logic [SL_W-1:0]     sel;
   logic [SL_W:0]       cand_sum;

`ifdef PERIPH_REQ_SYNC_EN
   logic [NUM_PERIPH:0] tx_s1, tx_s2, rx_s1, rx_s2;

   // Two-flop synchronizer on the raw request levels.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, independent of order.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_s1 <= '0;
         tx_s2 <= '0;
         rx_s1 <= '0;
         rx_s2 <= '0;
      end else begin
         tx_s1 <= periph_tx_req;
         tx_s2 <= tx_s1;
         rx_s1 <= periph_rx_req;
         rx_s2 <= rx_s1;
      end
   end

   assign tx_req_eff = tx_s2;
   assign rx_req_eff = rx_s2;
`else
   assign tx_req_eff = periph_tx_req;
   assign rx_req_eff = periph_rx_req;
`endif

   // Bit 0 of every vector is reserved and deliberately ignored.
   logic unused_bits;
   assign unused_bits = ^{tx_req_eff[0], rx_req_eff[0], tx_en[0], rx_en[0]};

   // A slot is owned by the FSM from grant until its clear pulse ends.
   assign owned = (state_q != IDLE);

   // Map peripheral vectors onto the slot ring and back.
   for (genvar p = 1; p <= NUM_PERIPH; p++) begin : g_map
      assign req_slot[2*p-2] = tx_req_eff[p];
      assign req_slot[2*p-1] = rx_req_eff[p];
      assign en_slot[2*p-2]  = tx_en[p];
      assign en_slot[2*p-1]  = rx_en[p];
      assign tx_pend[p]      = pend_q[2*p-2];
      assign rx_pend[p]      = pend_q[2*p-1];
      assign periph_tx_clr[p] = (state_q == CLR) && (ptr_q == SL_W'(2*p-2));
      assign periph_rx_clr[p] = (state_q == CLR) && (ptr_q == SL_W'(2*p-1));
   end
   assign tx_pend[0]       = 1'b0;
   assign rx_pend[0]       = 1'b0;
   assign periph_tx_clr[0] = 1'b0;
   assign periph_rx_clr[0] = 1'b0;

   // Per-slot pending latch and holdoff counter.
   for (genvar k = 0; k < NS; k++) begin : g_slot
      logic            pend_r;
      logic [HO_W-1:0] hold_q;
      logic            mine;

      assign mine      = owned && (ptr_q == SL_W'(k));
      assign pend_q[k] = pend_r;

      // Capture when enabled and out of holdoff; release on enable drop or
      // at the end of this slot's clear pulse.
      always_ff @(posedge clk) begin
         if (reset) begin
            pend_r <= 1'b0;
            hold_q <= '0;
         end else begin
            if (hold_q != '0) begin
               hold_q <= hold_q - HO_W'(1);
            end
            if (mine) begin
               if (clr_done) begin
                  pend_r <= 1'b0;
                  hold_q <= HO_W'(HOLDOFF);
               end
            end else if (!en_slot[k]) begin
               pend_r <= 1'b0;
            end else if (req_slot[k] && (hold_q == '0)) begin
               pend_r <= 1'b1;
            end
         end
      end
   end

   // Round-robin search: first pending slot strictly after the pointer.
   // NOTE: every signal written here gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      found    = 1'b0;
      sel      = ptr_q;
      cand_sum = '0;
      for (int i = 1; i <= NS; i++) begin
         cand_sum = {1'b0, ptr_q} + (SL_W + 1)'(i);
         if (cand_sum >= NS_W) begin
            cand_sum = cand_sum - NS_W;
         end
         if (!found && pend_q[cand_sum[SL_W-1:0]]) begin
            found = 1'b1;
            sel   = cand_sum[SL_W-1:0];
         end
      end
   end

   // Grant FSM next-state logic.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gp_d     = gp_q;
      gd_d     = gd_q;
      cnt_d    = cnt_q;
      clr_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = GRANT;
               ptr_d   = sel;
               gp_d    = IDX_W'(sel >> 1) + IDX_W'(1);
               gd_d    = sel[0];
            end
         end
         GRANT: begin
            if (gnt_ready) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (xfer_done) begin
               state_d = CLR;
               cnt_d   = CNT_W'(CLR_CYCLES - 1);
            end
         end
         CLR: begin
            if (cnt_q == '0) begin
               state_d  = IDLE;
               clr_done = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Grant FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= PTR_RST;
         gp_q    <= '0;
         gd_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gp_q    <= gp_d;
         gd_q    <= gd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt_valid  = (state_q == GRANT);
   assign gnt_periph = gp_q;
   assign gnt_dir    = gd_q;
   assign busy       = owned;

endmodule
